// File: rtl/hex_scan_controller.sv
// Scans a double-buffered display word across NUM_DIGITS digits through one shared hex decoder.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module hex_scan_controller #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scan_en,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  input  logic [NUM_DIGITS-1:0]     load_blank,
  output logic [3:0]                nib_out,
  output logic [NUM_DIGITS-1:0]     dig_en,
  output logic                      blank,
  output logic                      frame_done
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  typedef enum logic [0:0] {StIdle, StScan} state_t;

  state_t                    state_q, state_d;
  logic [CntW-1:0]           div_cnt_q;
  logic [IdxW-1:0]           idx_q;
  logic                      pending_q;
  logic [4*NUM_DIGITS-1:0]   active_data_q, shadow_data_q;
  logic [NUM_DIGITS-1:0]     active_blank_q, shadow_blank_q;

  logic                      accept;
  logic                      tick;
  logic                      last_idx;
  logic                      wrap;
  logic [NUM_DIGITS-1:0]     lz;
  logic [3:0]                cur_nib;
  logic                      cur_blank;

  assign accept   = load_valid & ~pending_q;
  assign tick     = (div_cnt_q == CntW'(REFRESH_DIV - 1));
  assign last_idx = (idx_q == IdxW'(NUM_DIGITS - 1));
  assign wrap     = (state_q == StScan) & scan_en & tick & last_idx;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leaves idle on the first load, returns only through reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StScan;
      StScan:  state_d = StScan;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_ready = ~pending_q;
    frame_done = wrap;
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic hi_zero;
    lz      = '0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero = hi_zero & (active_data_q[4*i +: 4] == 4'h0);
      lz[i]   = hi_zero;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = active_data_q[4*i +: 4];
        cur_blank = active_blank_q[i] | lz[i];
      end
    end
  end

  // Scan datapath and registered decoder outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q      <= '0;
      idx_q          <= '0;
      pending_q      <= 1'b0;
      active_data_q  <= '0;
      shadow_data_q  <= '0;
      active_blank_q <= '1;
      shadow_blank_q <= '1;
      nib_out        <= 4'h0;
      dig_en         <= '0;
      blank          <= 1'b1;
    end else if (state_q == StIdle) begin
      if (accept) begin
        active_data_q  <= load_data;
        active_blank_q <= load_blank;
        div_cnt_q      <= '0;
        idx_q          <= '0;
      end
    end else begin
      if (scan_en) begin
        div_cnt_q <= tick ? '0 : div_cnt_q + CntW'(1);
        if (tick) begin
          idx_q <= last_idx ? '0 : idx_q + IdxW'(1);
        end
        dig_en  <= NUM_DIGITS'(1) << idx_q;
        nib_out <= cur_nib;
        blank   <= cur_blank;
      end
      // Swap only at the frame boundary so a frame never mixes old and new words
      if (wrap && pending_q) begin
        active_data_q  <= shadow_data_q;
        active_blank_q <= shadow_blank_q;
        pending_q      <= 1'b0;
      end
      // accept implies pending_q == 0, so this never collides with the swap above
      if (accept) begin
        shadow_data_q  <= load_data;
        shadow_blank_q <= load_blank;
        pending_q      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_controller.sv
// Directed bench for hex_scan_controller with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_hex_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_en;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_blank;
  logic [3:0]  nib_out;
  logic [3:0]  dig_en;
  logic        blank;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  hex_scan_controller #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_blank(load_blank),
    .nib_out   (nib_out),
    .dig_en    (dig_en),
    .blank     (blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dig_en"}, 32'(dig_en), 32'h0);
    chk({tag, "_nib"}, 32'(nib_out), 32'h0);
    chk({tag, "_blank"}, 32'(blank), 32'h1);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'h1);
  endtask

  // Frames 0-1 show 1234, 2-3 ABCD, 4+ 5678 with digit 1 blanked
  function automatic logic [15:0] exp_data(input int f);
    if (f < 2) return 16'h1234;
    if (f < 4) return 16'hABCD;
    return 16'h5678;
  endfunction

  function automatic logic [3:0] exp_blk(input int f);
    return (f >= 4) ? 4'b0010 : 4'b0000;
  endfunction

  // n = enabled clock edges since the load that started scanning
  task automatic check_slot(input int n, input logic exp_ready);
    int d;
    int f;
    logic [15:0] dat;
    logic [3:0]  bl;
    d   = ((n - 1) >> 2) & 3;
    f   = (n - 1) >> 4;
    dat = exp_data(f);
    bl  = exp_blk(f);
    chk($sformatf("n%0d_dig_en", n), 32'(dig_en), 32'(4'b0001 << d));
    chk($sformatf("n%0d_nib", n), 32'(nib_out), 32'((dat >> (4 * d)) & 16'hF));
    chk($sformatf("n%0d_blank", n), 32'(blank), 32'(bl[d]));
    chk($sformatf("n%0d_frame_done", n), 32'(frame_done), 32'((n % 16) == 15));
    chk($sformatf("n%0d_load_ready", n), 32'(load_ready), 32'(exp_ready));
  endtask

  initial begin
    logic [15:0] lzw;
    logic        exp_b;
    reset      = 1'b1;
    scan_en    = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    load_blank = 4'h0;
    #12;
    chk_idle("in_reset");
    reset = 1'b0;

    repeat (6) step();
    chk_idle("idle_no_load");

    // First load starts scanning; outputs stay at reset values for the accept edge
    load_valid = 1'b1;
    load_data  = 16'h1234;
    load_blank = 4'b0000;
    step();
    load_valid = 1'b0;
    chk("n0_dig_en", 32'(dig_en), 32'h0);
    chk("n0_blank", 32'(blank), 32'h1);

    // Mid-frame load at edge 21, load coincident with wrap tick at edge 48
    for (int n = 1; n <= 82; n++) begin
      if (n == 21) begin
        load_valid = 1'b1;
        load_data  = 16'hABCD;
        load_blank = 4'b0000;
      end else if (n == 48) begin
        load_valid = 1'b1;
        load_data  = 16'h5678;
        load_blank = 4'b0010;
      end else begin
        load_valid = 1'b0;
      end
      step();
      load_valid = 1'b0;
      check_slot(n, !((n >= 21 && n <= 31) || (n >= 48 && n <= 63)));
    end

    // Freeze mid-digit for 10 clocks
    scan_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_slot(82, 1'b1);
    end
    scan_en = 1'b1;
    for (int n = 83; n <= 96; n++) begin
      step();
      check_slot(n, 1'b1);
    end

    // Pending load discarded by an asynchronous reset
    load_valid = 1'b1;
    load_data  = 16'h9999;
    load_blank = 4'b0000;
    step();
    load_valid = 1'b0;
    chk("pending_load_ready", 32'(load_ready), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("async_reset");
    reset = 1'b0;
    repeat (3) step();
    chk_idle("after_reset");

    // Leading-zero cases: 0x0040 then 0x0000
    for (int t = 0; t < 2; t++) begin
      lzw = (t == 0) ? 16'h0040 : 16'h0000;
      reset = 1'b1;
      #1;
      reset = 1'b0;
      step();
      load_valid = 1'b1;
      load_data  = lzw;
      load_blank = 4'b0000;
      step();
      load_valid = 1'b0;
      for (int n = 1; n <= 16; n++) begin
        int d;
        step();
        d = ((n - 1) >> 2) & 3;
`ifdef LEADING_ZERO_BLANK_EN
        exp_b = (t == 0) ? (d >= 2) : (d > 0);
`else
        exp_b = 1'b0;
`endif
        chk($sformatf("lz%0d_n%0d_dig_en", t, n), 32'(dig_en), 32'(4'b0001 << d));
        chk($sformatf("lz%0d_n%0d_nib", t, n), 32'(nib_out), 32'((lzw >> (4 * d)) & 16'hF));
        chk($sformatf("lz%0d_n%0d_blank", t, n), 32'(blank), 32'(exp_b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
